// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants, fetch FSM state encoding.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 12;
    localparam int OPC_W   = 4;
    localparam int OPND_W  = 8;

    localparam logic [OPC_W-1:0] OP_B    = 4'b0101;
    localparam logic [OPC_W-1:0] OP_BZ   = 4'b1000;
    localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_EXEC   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_HALT   = 3'd3,
        ST_FAULT  = 3'd4
    } fetch_state_t;

    // Branch opcodes hand the next-PC decision to the PC unit instead of incrementing.
    function automatic logic is_branch(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_B) || (opcode == OP_BZ);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: address + request out, ack + data back.
// Latency: data is valid in the same cycle ack is high.
// Backpressure: memory stretches a fetch by holding ack low while req stays high.
// master: fetch unit (drives addr/req); slave: instruction memory (drives ack/data).
interface instr_fetch_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]    addr;
    logic               req;
    logic               ack;
    logic [INSTR_W-1:0] data;

    modport master (output addr, req, input ack, data);
    modport slave  (input addr, req, output ack, data);

endinterface

// File: rtl/instr_fetch.sv
// Fetch/sequencing stage: reads the instruction at pc into IR, waits for execution, pulses the PC update.
// Latency: 3 cycles per instruction minimum (FETCH, EXEC, UPDATE) with zero-wait memory and immediate exec_done.
// Backpressure: FETCH holds req until ack (faults after FETCH_TIMEOUT cycles); EXEC holds until exec_done.
// Ports: clk, reset_ir_n (async, active-low), pc in; imem (master modport); exec_done in;
//        ir_opcode/ir_operand_addr/ir_valid, REPC/INC update pulse, sticky halted/fetch_fault out.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16    // legal range 2..255
) (
    input  logic              clk,
    input  logic              reset_ir_n,
    input  logic [PC_W-1:0]   pc,
    instr_fetch_if.master     imem,
    input  logic              exec_done,
    output logic [OPC_W-1:0]  ir_opcode,
    output logic [OPND_W-1:0] ir_operand_addr,
    output logic              ir_valid,
    output logic              REPC,
    output logic              INC,
    output logic              halted,
    output logic              fetch_fault
);

    // Last FETCH cycle index at which an ack is still accepted.
    localparam logic [7:0] TIMER_LAST = 8'(FETCH_TIMEOUT - 1);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [7:0]         timer_q, timer_d;
    logic               ir_load;

    always_ff @(posedge clk or negedge reset_ir_n) begin
        if (!reset_ir_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (ir_load) begin
                ir_q <= imem.data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ir_load = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem.ack) begin
                    ir_load = 1'b1;
                    timer_d = '0;
                    state_d = ST_EXEC;
                end else if (timer_q >= TIMER_LAST) begin
                    state_d = ST_FAULT;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_EXEC: begin
                if (ir_q[11:8] == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (exec_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    // Reset comes up in FETCH; gating req keeps the bus quiet until reset is released.
    assign imem.req        = reset_ir_n && (state_q == ST_FETCH);
    assign imem.addr       = pc;
    assign ir_opcode       = ir_q[11:8];
    assign ir_operand_addr = ir_q[7:0];
    assign ir_valid        = (state_q == ST_EXEC) || (state_q == ST_UPDATE);
    assign REPC            = (state_q == ST_UPDATE);
    assign INC             = (state_q == ST_UPDATE) && !is_branch(ir_q[11:8]);
    assign halted          = (state_q == ST_HALT);
    assign fetch_fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory / datapath / PC-unit environment, directed timing checks and a randomized
// program run scored against a trace predicted from memory contents.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int TO     = 16;
    localparam int N_RAND = 150;

    typedef struct {
        logic [11:0] instr;
        logic        inc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_ir_n;
    logic [9:0] pc;
    logic       exec_done;
    logic [3:0] ir_opcode;
    logic [7:0] ir_operand_addr;
    logic       ir_valid, REPC, INC, halted, fetch_fault;

    instr_fetch_if imem();

    instr_fetch #(.FETCH_TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset_ir_n      (reset_ir_n),
        .pc              (pc),
        .imem            (imem),
        .exec_done       (exec_done),
        .ir_opcode       (ir_opcode),
        .ir_operand_addr (ir_operand_addr),
        .ir_valid        (ir_valid),
        .REPC            (REPC),
        .INC             (INC),
        .halted          (halted),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [1024];
    int   n_cmp = 0;
    int   n_err = 0;
    int   delay_cfg = 0;   // <0: random 0..4 wait cycles, else fixed
    int   exec_cfg  = 1;   // 0: exec_done low, 1: high, 2: random
    bit   spur_en   = 1'b0;
    bit   mon_en    = 1'b0;
    int   repc_seen = 0;
    exp_t exp_q [$];
    exp_t mon_e;
    logic [9:0] ref_pc;
    logic [3:0] ref_op;
    logic       ref_inc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PC unit behaviour: increment, or branch evaluation (B always taken, BZ taken when operand bit 0 is 1).
    function automatic logic [9:0] pc_unit(input logic [9:0] p, input logic [3:0] op,
                                           input logic [7:0] opnd, input logic inc);
        if (inc) return p + 10'd1;
        if (op == 4'h8 && !opnd[0]) return p + 10'd1;
        return {2'b00, opnd};
    endfunction

    // Environment: PC unit, instruction memory with wait states, datapath exec_done.
    int wait_cnt = 0;
    int cur_delay = 0;
    initial begin
        imem.ack  = 1'b0;
        imem.data = '0;
        exec_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_ir_n && REPC) pc = pc_unit(pc, ir_opcode, ir_operand_addr, INC);
            if (reset_ir_n && imem.req) begin
                if (wait_cnt == 0) cur_delay = (delay_cfg < 0) ? int'($urandom_range(0, 4)) : delay_cfg;
                if (wait_cnt == cur_delay) begin
                    imem.ack  = 1'b1;
                    imem.data = mem[imem.addr];
                    wait_cnt  = 0;
                end else begin
                    imem.ack  = 1'b0;
                    imem.data = 12'($urandom);
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                imem.ack  = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
                imem.data = 12'($urandom);
            end
            case (exec_cfg)
                0:       exec_done = 1'b0;
                1:       exec_done = 1'b1;
                default: exec_done = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Scoreboard monitor: every REPC pulse retires the next predicted instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && reset_ir_n) begin
                if (REPC) begin
                    if (exp_q.size() == 0) begin
                        check("repc_unexpected", 32'(REPC), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_opcode",  32'(ir_opcode),       32'(mon_e.instr[11:8]));
                        check("sb_operand", 32'(ir_operand_addr), 32'(mon_e.instr[7:0]));
                        check("sb_inc",     32'(INC),             32'(mon_e.inc));
                        check("sb_ir_valid", 32'(ir_valid),       32'd1);
                        repc_seen++;
                    end
                end else begin
                    check("inc_idle", 32'(INC), 32'd0);
                end
                if (imem.req) check("addr_is_pc", 32'(imem.addr), 32'(pc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic release_reset();
        @(posedge clk);
        #1 reset_ir_n = 1'b1;
    endtask

    initial begin
        reset_ir_n = 1'b0;
        pc = 10'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 12'h000;
        mem[10'h000] = 12'h312;
        mem[10'h001] = 12'h555;
        mem[10'h055] = 12'h8AA;
        mem[10'h056] = 12'h7C3;
        mem[10'h057] = 12'h0AB;
        mem[10'h058] = 12'h0CD;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req",       32'(imem.req),        32'd0);
        check("rst_repc",      32'(REPC),            32'd0);
        check("rst_inc",       32'(INC),             32'd0);
        check("rst_ir_valid",  32'(ir_valid),        32'd0);
        check("rst_halted",    32'(halted),          32'd0);
        check("rst_fault",     32'(fetch_fault),     32'd0);
        check("rst_ir",        32'({ir_opcode, ir_operand_addr}), 32'd0);

        // Zero-wait run: 312 (inc), 555 (B), 8AA (BZ not taken)
        delay_cfg = 0; exec_cfg = 1;
        release_reset();
        @(negedge clk); check("c1_req", 32'(imem.req), 32'd1); check("c1_addr", 32'(imem.addr), 32'h000);
                        check("c1_ir_valid", 32'(ir_valid), 32'd0);
        @(negedge clk); check("c2_ir_valid", 32'(ir_valid), 32'd1); check("c2_op", 32'(ir_opcode), 32'h3);
                        check("c2_opnd", 32'(ir_operand_addr), 32'h12); check("c2_repc", 32'(REPC), 32'd0);
        @(negedge clk); check("c3_repc", 32'(REPC), 32'd1); check("c3_inc", 32'(INC), 32'd1);
        @(negedge clk); check("c4_req", 32'(imem.req), 32'd1); check("c4_addr", 32'(imem.addr), 32'h001);
        @(negedge clk); check("c5_op", 32'(ir_opcode), 32'h5);
        @(negedge clk); check("b_repc", 32'(REPC), 32'd1); check("b_inc", 32'(INC), 32'd0);
        @(negedge clk); check("b_target", 32'(imem.addr), 32'h055); check("b_req", 32'(imem.req), 32'd1);
        @(negedge clk); check("bz_op", 32'(ir_opcode), 32'h8); check("bz_opnd", 32'(ir_operand_addr), 32'hAA);
        @(negedge clk); check("bz_repc", 32'(REPC), 32'd1); check("bz_inc", 32'(INC), 32'd0);

        // Five wait states: req high for six cycles at a stable address
        delay_cfg = 5;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ws_req", 32'(imem.req), 32'd1);
            check("ws_addr", 32'(imem.addr), 32'h056);
            check("ws_fault", 32'(fetch_fault), 32'd0);
        end
        @(negedge clk); check("ws_req_drop", 32'(imem.req), 32'd0); check("ws_ir", 32'({ir_opcode, ir_operand_addr}), 32'h7C3);
        @(negedge clk); check("ws_repc", 32'(REPC), 32'd1); check("ws_inc", 32'(INC), 32'd1);

        // Ack in the 16th FETCH cycle: no fault
        delay_cfg = TO - 1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("tb_req", 32'(imem.req), 32'd1);
            check("tb_fault", 32'(fetch_fault), 32'd0);
        end
        @(negedge clk); check("tb_loaded", 32'(ir_valid), 32'd1); check("tb_nofault", 32'(fetch_fault), 32'd0);
                        check("tb_ir", 32'({ir_opcode, ir_operand_addr}), 32'h0AB);
        @(negedge clk); check("tb_repc", 32'(REPC), 32'd1);

        // No ack: fault after 16 FETCH cycles
        delay_cfg = TO;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_req", 32'(imem.req), 32'd1);
            check("to_fault_early", 32'(fetch_fault), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_fault", 32'(fetch_fault), 32'd1);
            check("to_req_off", 32'(imem.req), 32'd0);
            check("to_ir_valid", 32'(ir_valid), 32'd0);
        end

        // HALT
        reset_ir_n = 1'b0;
        #1 check("rst2_fault", 32'(fetch_fault), 32'd0); check("rst2_req", 32'(imem.req), 32'd0);
        pc = 10'h100; mem[10'h100] = 12'hF00; delay_cfg = 0;
        repeat (2) @(negedge clk);
        release_reset();
        @(negedge clk); check("h_req", 32'(imem.req), 32'd1);
        @(negedge clk); check("h_exec", 32'(ir_valid), 32'd1); check("h_not_yet", 32'(halted), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("h_halted", 32'(halted), 32'd1);
            check("h_ir_valid", 32'(ir_valid), 32'd0);
            check("h_repc", 32'(REPC), 32'd0);
            check("h_req", 32'(imem.req), 32'd0);
        end
        check("h_ir_kept", 32'({ir_opcode, ir_operand_addr}), 32'hF00);

        // Async reset during EXEC with exec_done pending
        reset_ir_n = 1'b0;
        pc = 10'h200; mem[10'h200] = 12'h1AB; exec_cfg = 0;
        repeat (2) @(negedge clk);
        release_reset();
        repeat (3) @(negedge clk);
        check("ar_in_exec", 32'(ir_valid), 32'd1); check("ar_halted", 32'(halted), 32'd0);
        @(posedge clk); #2 reset_ir_n = 1'b0;
        #1;
        check("ar_ir_valid", 32'(ir_valid), 32'd0);
        check("ar_repc", 32'(REPC), 32'd0);
        check("ar_inc", 32'(INC), 32'd0);
        check("ar_ir", 32'({ir_opcode, ir_operand_addr}), 32'd0);
        check("ar_req", 32'(imem.req), 32'd0);
        pc = 10'h201; mem[10'h201] = 12'h2CD; exec_cfg = 1;
        repeat (2) @(negedge clk);
        release_reset();
        @(negedge clk); check("ar2_req", 32'(imem.req), 32'd1); check("ar2_addr", 32'(imem.addr), 32'h201);
        @(negedge clk); check("ar2_ir", 32'({ir_opcode, ir_operand_addr}), 32'h2CD);
        @(negedge clk); check("ar2_repc", 32'(REPC), 32'd1); check("ar2_inc", 32'(INC), 32'd1);

        // Randomized program: predict the retired instruction trace from memory contents
        reset_ir_n = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = {4'($urandom_range(0, 14)), 8'($urandom)};
        ref_pc = 10'($urandom);
        pc = ref_pc;
        exp_q.delete();
        for (int i = 0; i < N_RAND + 5; i++) begin
            ref_op  = mem[ref_pc][11:8];
            ref_inc = !(ref_op == 4'h5 || ref_op == 4'h8);
            exp_q.push_back('{instr: mem[ref_pc], inc: ref_inc});
            ref_pc  = pc_unit(ref_pc, ref_op, mem[ref_pc][7:0], ref_inc);
        end
        delay_cfg = -1; exec_cfg = 2; spur_en = 1'b1; repc_seen = 0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        release_reset();
        for (int cyc = 0; cyc < 10000 && repc_seen < N_RAND; cyc++) @(negedge clk);
        check("rand_progress", 32'(repc_seen >= N_RAND), 32'd1);
        mon_en = 1'b0;
        check("rand_no_fault", 32'(fetch_fault), 32'd0);
        check("rand_no_halt", 32'(halted), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
